// File: rtl/scan_loader.sv
// scan_loader: serial-load controller for the pattern-buffer bank.
// Accepts bytes over valid/ready and shifts each one MSB-first into the
// buffer selected by saddr, one sclk pulse per bit.
// Build option: define SCAN_READBACK_EN to capture the bank's sout stream
// into rd_byte/rd_valid. Without it, rd_byte/rd_valid are tied to 0.
//
// state | meaning
// IDLE  | ready for a byte; opens a frame (latches saddr) if none is open
// SETUP | sclk low, sin presenting the current bit, sout sampled
// PULSE | sclk high for one cycle; shift register advances
module scan_loader #(
  parameter int BUFFER_SIZE  = 22,
  parameter int BUFFER_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic [BUFFER_WIDTH-1:0] load_byte_i,
  input  logic [2:0]              load_buf_i,
  input  logic                    load_last_i,
  output logic                    sclk_o,
  output logic                    sin_o,
  output logic [2:0]              saddr_o,
  input  logic                    sout_i,
  output logic [BUFFER_WIDTH-1:0] rd_byte_o,
  output logic                    rd_valid_o,
  output logic                    frame_done_o,
  output logic                    frame_err_o
);

  localparam int BIT_W = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;
  localparam int CNT_W = $clog2(BUFFER_SIZE + 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_SIZE = CNT_W'(BUFFER_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [BUFFER_WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]        byte_inc;
  logic                    last_q, last_d;
  logic                    open_q, open_d;
  logic [2:0]              saddr_q, saddr_d;
  logic                    sclk_q, sclk_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    byte_end;

  // Last PULSE of a byte: the cycle before the completion strobes.
  assign byte_end = (state_q == PULSE) && (bit_cnt_q == '0);

  // Saturating byte count including the byte now completing.
  assign byte_inc = (byte_cnt_q == CNT_MAX) ? byte_cnt_q : byte_cnt_q + CNT_W'(1);

  // State and datapath registers; reset aborts any shift in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      last_q     <= 1'b0;
      open_q     <= 1'b0;
      saddr_q    <= '0;
      sclk_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      last_q     <= last_d;
      open_q     <= open_d;
      saddr_q    <= saddr_d;
      sclk_q     <= sclk_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic. Outputs are computed one cycle ahead so every
  // bank-facing signal comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    last_d     = last_q;
    open_d     = open_q;
    saddr_d    = saddr_q;
    sclk_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_valid_i && ready_q) begin
          shreg_d   = load_byte_i;
          last_d    = load_last_i;
          bit_cnt_d = BIT_W'(BUFFER_WIDTH - 1);
          state_d   = SETUP;
          // saddr only moves here, with sclk low, so the bank's gated
          // per-buffer clocks never see a glitch.
          if (!open_q) begin
            saddr_d    = load_buf_i;
            byte_cnt_d = '0;
            open_d     = 1'b1;
          end
        end
      end
      SETUP: begin
        sclk_d  = 1'b1;
        state_d = PULSE;
      end
      PULSE: begin
        shreg_d = {shreg_q[BUFFER_WIDTH-2:0], 1'b0};
        if (bit_cnt_q == '0) begin
          state_d    = IDLE;
          byte_cnt_d = byte_inc;
          if (last_q) begin
            open_d = 1'b0;
            done_d = 1'b1;
            err_d  = (byte_inc != CNT_SIZE);
          end
        end else begin
          bit_cnt_d = bit_cnt_q - BIT_W'(1);
          state_d   = SETUP;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  // sin is the shift-register MSB: loaded on accept, so it is valid in
  // the SETUP cycle and held through the following PULSE.
  assign sin_o        = shreg_q[BUFFER_WIDTH-1];
  assign sclk_o       = sclk_q;
  assign saddr_o      = saddr_q;
  assign load_ready_o = ready_q;
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;

`ifdef SCAN_READBACK_EN
  logic [BUFFER_WIDTH-1:0] cap_q;
  logic [BUFFER_WIDTH-1:0] rd_byte_q;
  logic                    rd_valid_q;

  // Sample sout before each pulse; the bank presents the oldest bit first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
    end else if (state_q == SETUP) begin
      cap_q <= {cap_q[BUFFER_WIDTH-2:0], sout_i};
    end
  end

  // Publish the captured byte alongside the byte-completion edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_byte_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= byte_end;
      if (byte_end) begin
        rd_byte_q <= cap_q;
      end
    end
  end

  assign rd_byte_o  = rd_byte_q;
  assign rd_valid_o = rd_valid_q;
`else
  logic unused_sout;

  assign unused_sout = sout_i;
  assign rd_byte_o   = '0;
  assign rd_valid_o  = 1'b0;
`endif

endmodule
